jtag_rbb_engine: RTL and testbench

Synthesizable hardware engine for the OpenOCD remote_bitbang ASCII protocol.
- Consumes a byte stream (valid/ready) from any transport (UART, TCP offload, DPI byte pipe).
- Buffers the bytes in a parametrised command FIFO and executes them at a programmable pin rate.
- Drives the JTAG pins and returns TDO samples as ASCII bytes on a response stream.
- Successor to the DPI bit-bang bridge: adds buffering, back-pressure, TCK pacing, TDO synchronisation and protocol error counting.

---
 rtl/jtag_rbb_pkg.sv | 23 ++
 rtl/jtag_rbb_fifo.sv | 52 +++++
 rtl/jtag_rbb_engine.sv | 184 ++++++++++++++++++
 tb/tb_jtag_rbb_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_rbb_pkg.sv
// Shared constants, FSM state type and sizing helpers for the remote_bitbang engine.
package jtag_rbb_pkg;

  localparam logic [7:0] CH_WR0       = 8'h30;
  localparam logic [7:0] CH_RST0      = 8'h72;
  localparam logic [7:0] CH_READ      = 8'h52;
  localparam logic [7:0] CH_BLINK_ON  = 8'h42;
  localparam logic [7:0] CH_BLINK_OFF = 8'h62;
  localparam logic [7:0] CH_QUIT      = 8'h51;
  localparam logic [7:0] RESP_BASE    = 8'h30;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    READ_WAIT = 2'd2
  } rbb_state_e;

  // The hold counter runs 0..n-1; keep at least one bit so HOLD_CYCLES=0/1 still elaborate.
  function automatic int unsigned hold_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtag_rbb_fifo.sv
// Non-fall-through byte FIFO with synchronous reset and flush; head is visible while non-empty.
module jtag_rbb_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtag_rbb_engine.sv
// OpenOCD remote_bitbang command engine: buffered byte stream in, JTAG pins and ASCII TDO samples out.
module jtag_rbb_engine
  import jtag_rbb_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 16,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TDO_SYNC    = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             jtag_tck_o,
  output logic             jtag_tms_o,
  output logic             jtag_tdi_o,
  output logic             jtag_trst_o,
  output logic             jtag_srst_o,
  input  logic             jtag_tdo_i,
  output logic             blink_o,
  output logic             quit_o,
  output logic             busy_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int unsigned HOLD_W = hold_cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  rbb_state_e       state;
  logic [HOLD_W-1:0] hold_cnt;

  logic [7:0] head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       tdo_s;

  logic       is_pin;
  logic       is_rst;
  logic [1:0] rst_v;

  logic             tck_q, tms_q, tdi_q, trst_q, srst_q;
  logic             blink_q, quit_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic [ERR_W-1:0] err_q;

  assign rx_ready_o = enable_i & ~fifo_full & ~rst_i;
  assign push       = rx_valid_i & rx_ready_o;
  assign pop        = enable_i & (state == IDLE) & ~fifo_empty;

  jtag_rbb_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~enable_i),
    .push_i  (push),
    .data_i  (rx_data_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  generate
    if (TDO_SYNC == 0) begin : g_tdo_direct
      assign tdo_s = jtag_tdo_i;
    end else begin : g_tdo_sync
      logic [TDO_SYNC-1:0] sync_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= jtag_tdo_i;
          for (int unsigned i = 1; i < TDO_SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign tdo_s = sync_q[TDO_SYNC-1];
    end
  endgenerate

  // Pin writes carry the value in the low three bits; reset writes are offset from 'r'.
  always_comb begin
    is_pin = (head >= CH_WR0) && (head <= (CH_WR0 + 8'd7));
    is_rst = (head >= CH_RST0) && (head <= (CH_RST0 + 8'd3));
    rst_v  = 2'(head - CH_RST0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b0;
      tdi_q      <= 1'b0;
      trst_q     <= 1'b0;
      srst_q     <= 1'b0;
      blink_q    <= 1'b0;
      quit_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= '0;
    end else if (!enable_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b0;
      tdi_q      <= 1'b0;
      trst_q     <= 1'b0;
      srst_q     <= 1'b0;
      blink_q    <= 1'b0;
      quit_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      quit_q <= 1'b0;
      if (tx_valid_q && tx_ready_i) tx_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (is_pin) begin
              {tck_q, tms_q, tdi_q} <= head[2:0];
              if (HOLD_CYCLES > 0) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end
            end else if (is_rst) begin
              {trst_q, srst_q} <= rst_v;
            end else if (head == CH_BLINK_ON) begin
              blink_q <= 1'b1;
            end else if (head == CH_BLINK_OFF) begin
              blink_q <= 1'b0;
            end else if (head == CH_QUIT) begin
              quit_q <= 1'b1;
            end else if (head == CH_READ) begin
              if (!tx_valid_q) begin
                tx_data_q  <= RESP_BASE | {7'b0, tdo_s};
                tx_valid_q <= 1'b1;
              end else begin
                state <= READ_WAIT;
              end
            end else if (err_q != '1) begin
              err_q <= err_q + ERR_W'(1);
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= IDLE;
          else hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        READ_WAIT: begin
          // A handshake and reload in the same cycle keeps tx_valid high with fresh data.
          if (!tx_valid_q || tx_ready_i) begin
            tx_data_q  <= RESP_BASE | {7'b0, tdo_s};
            tx_valid_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign jtag_tck_o  = tck_q;
  assign jtag_tms_o  = tms_q;
  assign jtag_tdi_o  = tdi_q;
  assign jtag_trst_o = trst_q;
  assign jtag_srst_o = srst_q;
  assign blink_o     = blink_q;
  assign quit_o      = quit_q;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign err_cnt_o   = err_q;
  assign busy_o      = ~fifo_empty | (state != IDLE);

endmodule

// File: tb/tb_jtag_rbb_engine.sv
// Directed self-checking bench for jtag_rbb_engine with hand-computed expectations.
module tb_jtag_rbb_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tck, tms, tdi, trst, srst;
  logic       tdo;
  logic       blink, quit, busy;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int         resp_cnt = 0;
  int         resp_ok  = 0;
  int         acc_cnt  = 0;
  int         quit_cnt = 0;
  logic [7:0] exp_resp = 8'h31;

  jtag_rbb_engine #(
    .CMD_DEPTH   (16),
    .HOLD_CYCLES (2),
    .TDO_SYNC    (2),
    .ERR_W       (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .jtag_tck_o  (tck),
    .jtag_tms_o  (tms),
    .jtag_tdi_o  (tdi),
    .jtag_trst_o (trst),
    .jtag_srst_o (srst),
    .jtag_tdo_i  (tdo),
    .blink_o     (blink),
    .quit_o      (quit),
    .busy_o      (busy),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk = ~clk;

  // Handshake monitor: counts accepted commands, delivered responses and quit pulses.
  always @(posedge clk) begin
    if (rx_valid && rx_ready) acc_cnt++;
    if (tx_valid && tx_ready) begin
      resp_cnt++;
      if (tx_data == exp_resp) resp_ok++;
    end
    if (quit) quit_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rx_ready) done = 1'b1;
      tick();
    end
    if (!done) check("rx_accept_timeout", 0, 1);
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base_acc, base_resp, base_ok, base_quit;
    bit drained;

    rst = 1'b1; enable = 1'b1; rx_valid = 1'b1; rx_data = "7";
    tx_ready = 1'b0; tdo = 1'b0;
    repeat (3) tick();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_pins", {tck, tms, tdi, trst, srst}, 5'b0);
    check("rst_blink_quit", {blink, quit}, 2'b0);
    check("rst_tx", {tx_valid, tx_data}, 9'h0);
    check("rst_err", err_cnt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; rx_valid = 1'b0;
    tick();

    // Pin writes "7","0","5" back-to-back: changes land 1, 4 and 7 edges after the first push.
    rx_valid = 1'b1; rx_data = "7"; tick();
    check("pin_before", {tck, tms, tdi}, 3'b000);
    rx_data = "0"; tick();
    check("pin_7", {tck, tms, tdi}, 3'b111);
    rx_data = "5"; tick();
    check("pin_7_hold1", {tck, tms, tdi}, 3'b111);
    rx_valid = 1'b0; tick();
    check("pin_7_hold2", {tck, tms, tdi}, 3'b111);
    tick();
    check("pin_0", {tck, tms, tdi}, 3'b000);
    tick(); tick();
    check("pin_0_hold", {tck, tms, tdi}, 3'b000);
    tick();
    check("pin_5", {tck, tms, tdi}, 3'b101);
    repeat (4) tick();
    check("pin_idle_busy", busy, 0);

    // Reads under back-pressure with TDO high.
    tdo = 1'b1; exp_resp = 8'h31;
    repeat (4) tick();
    base_resp = resp_cnt; base_ok = resp_ok;
    rx_valid = 1'b1; rx_data = "R"; tick();
    rx_data = "R"; tick();
    check("rd_first_valid", {tx_valid, tx_data}, 9'h131);
    rx_data = "0"; tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rd_hold_data", {tx_valid, tx_data}, 9'h131);
      tick();
    end
    check("rd_stall_pins", {tck, tms, tdi}, 3'b101);
    check("rd_stall_busy", busy, 1);
    check("rd_stall_resp", resp_cnt - base_resp, 0);
    tx_ready = 1'b1; tick();
    check("rd_reload", {tx_valid, tx_data}, 9'h131);
    tick();
    check("rd_drained", tx_valid, 0);
    check("rd_pins_after", {tck, tms, tdi}, 3'b000);
    check("rd_resp_cnt", resp_cnt - base_resp, 2);
    check("rd_resp_data", resp_ok - base_ok, 2);
    repeat (4) tick();

    // Reset lines, blink and quit.
    base_quit = quit_cnt;
    rx_valid = 1'b1; rx_data = "u"; tick();
    rx_data = "t"; tick();
    check("rst_lines_u", {trst, srst}, 2'b11);
    rx_data = "B"; tick();
    check("rst_lines_t", {trst, srst}, 2'b10);
    rx_data = "Q"; tick();
    check("blink_on", {blink, quit}, 2'b10);
    rx_data = "b"; tick();
    rx_valid = 1'b0;
    check("quit_pulse", quit, 1);
    tick();
    check("blink_off", {blink, quit}, 2'b00);
    repeat (3) tick();
    check("quit_count", quit_cnt - base_quit, 1);
    check("rst_lines_keep", {trst, srst, tck, tms, tdi}, 5'b10000);

    // FIFO full: one R loaded, one stalled in READ_WAIT, sixteen buffered.
    tx_ready = 1'b0; tdo = 1'b0; exp_resp = 8'h30;
    repeat (4) tick();
    base_acc = acc_cnt; base_resp = resp_cnt; base_ok = resp_ok;
    for (int i = 0; i < 18; i++) send_byte("R");
    check("full_ready_low", rx_ready, 0);
    check("full_acc18", acc_cnt - base_acc, 18);
    rx_valid = 1'b1; rx_data = "R";
    repeat (3) tick();
    check("full_no_accept", acc_cnt - base_acc, 18);
    tx_ready = 1'b1;
    send_byte("R");
    send_byte("R");
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      if (!busy && !tx_valid) drained = 1'b1;
      else tick();
    end
    if (!drained) check("full_drain_timeout", 0, 1);
    check("full_acc20", acc_cnt - base_acc, 20);
    check("full_resp20", resp_cnt - base_resp, 20);
    check("full_data20", resp_ok - base_ok, 20);

    // Unknown bytes and saturation.
    send_byte("X");
    send_byte(8'h0a);
    repeat (3) tick();
    check("err_two", err_cnt, 2);
    for (int i = 0; i < 253; i++) send_byte("X");
    repeat (3) tick();
    check("err_max", err_cnt, 8'hff);
    send_byte("X");
    repeat (3) tick();
    check("err_saturate", err_cnt, 8'hff);

    // Abort during HOLD with a command still queued.
    rx_valid = 1'b1; rx_data = "3"; tick();
    rx_data = "5"; tick();
    rx_valid = 1'b0;
    check("abort_pins_set", {tck, tms, tdi}, 3'b011);
    check("abort_busy_before", busy, 1);
    enable = 1'b0; tick();
    check("abort_pins", {tck, tms, tdi, trst, srst, blink}, 6'b0);
    check("abort_busy", busy, 0);
    check("abort_ready", rx_ready, 0);
    check("abort_err_kept", err_cnt, 8'hff);
    enable = 1'b1;
    repeat (5) tick();
    check("abort_flushed", {tck, tms, tdi, busy}, 4'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
